sdram_rom_loader: RTL

- Initiator-side client for the SDRAM controller's toggle-handshake ROM write port (romwr_req/romwr_ack/romwr_a/romwr_d).
- Accepts the byte stream from the IO-controller download interface and packs bytes into 16-bit big-endian words.
- Buffers words in a small FIFO and issues one toggle request per word, back-pressuring the download source.
- Reports the loaded image size and a completion pulse to the cartridge/mapper logic.

---
 rtl/sdram_rom_loader.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sdram_rom_loader.sv
// sdram_rom_loader: packs ioctl download bytes into 16-bit words and writes them through the SDRAM toggle-handshake ROM port
// Ports:
//   clk, init_n                         SDRAM clock, asynchronous active-low reset
//   ioctl_downl/wr/addr/data            download byte stream from the IO controller
//   ioctl_wait                          registered back-pressure to the download source
//   romwr_req/ack/a/d                   toggle-handshake word write port to the SDRAM controller
//   rom_size                            highest accepted byte address + 1
//   loader_done                         one-cycle pulse once the image has drained to SDRAM
//   overflow                            sticky, a byte or word was dropped
module sdram_rom_loader #(
   parameter int FIFO_DEPTH = 4,
   parameter bit BYTESWAP = 1'b0,
   parameter logic [7:0] PAD_BYTE = 8'hFF
) (
   input  logic        clk,
   input  logic        init_n,
   input  logic        ioctl_downl,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_data,
   output logic        ioctl_wait,
   output logic        romwr_req,
   input  logic        romwr_ack,
   output logic [22:0] romwr_a,
   output logic [15:0] romwr_d,
   output logic [24:0] rom_size,
   output logic        loader_done,
   output logic        overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
   typedef enum logic {D_IDLE, D_BUSY} dstate_t;
   state_t state;
   dstate_t dstate;
   logic downl_q, pend_v, skid_v;
   logic [7:0] pend_d;
   logic [22:0] pend_a, skid_a, w;
   logic [15:0] skid_d, pad_w, odd_w, join_d;
   logic [38:0] mem [FIFO_DEPTH];
   logic [38:0] push_w;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] cnt, cnt_nx;
   logic byte_ok, odd, join_w, skid_set, push, acc, pop;
   always_comb begin
      w = ioctl_addr[23:1];
      odd = ioctl_addr[0];
      byte_ok = state == LOAD && ioctl_wr && !skid_v;
      join_w = pend_v && pend_a == w;
      pad_w = BYTESWAP ? {PAD_BYTE, pend_d} : {pend_d, PAD_BYTE};
      odd_w = BYTESWAP ? {ioctl_data, PAD_BYTE} : {PAD_BYTE, ioctl_data};
      join_d = BYTESWAP ? {ioctl_data, pend_d} : {pend_d, ioctl_data};
      // an odd byte for a different word than the pending one needs two pushes: pad word now, odd word via skid
      skid_set = byte_ok && odd && pend_v && !join_w;
      push = skid_v || (state == FLUSH && pend_v) || (byte_ok && (pend_v || odd));
      push_w = skid_v ? {skid_a, skid_d} :
               (pend_v && !(byte_ok && odd && join_w)) ? {pend_a, pad_w} :
               {w, join_w ? join_d : odd_w};
      pop = dstate == D_BUSY && romwr_req == romwr_ack;
      acc = push && (cnt != CW'(FIFO_DEPTH) || pop);
      cnt_nx = cnt + CW'(acc) - CW'(pop);
   end
   always_ff @(posedge clk)
      if (acc) mem[wr_ptr] <= push_w;
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state <= IDLE;
         dstate <= D_IDLE;
         downl_q <= 1'b0;
         pend_v <= 1'b0;
         pend_d <= 8'h00;
         pend_a <= '0;
         skid_v <= 1'b0;
         skid_a <= '0;
         skid_d <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt <= '0;
         ioctl_wait <= 1'b0;
         romwr_req <= 1'b0;
         romwr_a <= '0;
         romwr_d <= '0;
         rom_size <= '0;
         loader_done <= 1'b0;
         overflow <= 1'b0;
      end else begin
         downl_q <= ioctl_downl;
         loader_done <= 1'b0;
         cnt <= cnt_nx;
         skid_v <= skid_set;
         ioctl_wait <= cnt_nx >= CW'(FIFO_DEPTH - 1) || skid_set;
         if (acc) wr_ptr <= wr_ptr + AW'(1);
         if (skid_set) begin
            skid_a <= w;
            skid_d <= odd_w;
         end
         if (byte_ok) begin
            if (ioctl_addr + 25'd1 > rom_size) rom_size <= ioctl_addr + 25'd1;
            pend_v <= !odd;
            if (!odd) begin
               pend_d <= ioctl_data;
               pend_a <= w;
            end
         end
         if (state == FLUSH && !skid_v) pend_v <= 1'b0;
         if ((push && !acc) || (state == LOAD && ioctl_wr && skid_v)) overflow <= 1'b1;
         if (state == IDLE && ioctl_downl && !downl_q) begin
            state <= LOAD;
            rom_size <= '0;
            overflow <= 1'b0;
            pend_v <= 1'b0;
         end else if (state == LOAD && !ioctl_downl) begin
            state <= FLUSH;
         end else if (state == FLUSH && cnt == '0 && !pend_v && !skid_v && romwr_req == romwr_ack) begin
            state <= IDLE;
            loader_done <= 1'b1;
         end
         // the head stays in the FIFO until acknowledged, so occupancy includes the in-flight word
         if (dstate == D_IDLE && cnt != '0) begin
            romwr_a <= mem[rd_ptr][38:16];
            romwr_d <= mem[rd_ptr][15:0];
            romwr_req <= ~romwr_req;
            dstate <= D_BUSY;
         end else if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            dstate <= D_IDLE;
         end
      end
   end
endmodule
